cal_flags_reg: RTL and testbench
================================

// Module: cal_flags_reg
// PURPOSE
//  Registered, parametrised ALU status-flag unit; next generation of the combinational C/N/Z/V calculator.
//  Sits after the ALU result/carry outputs and presents flags one clock later, qualified by a valid strobe.
//  Adds sticky carry/overflow flags and a saturating overflow-event counter that software/test logic can clear.
// PARAMETERS
//  WIDTH   32  ALU result width in bits (>=2); N taken from result[WIDTH-1]
//  CNT_W   8   width of overflow-event counter (>=1)
// PORTS
//  clk          in   1        system clock, all state updates on rising edge
//  reset        in   1        synchronous, active-high reset
//  in_valid     in   1        op/result/carry inputs are valid this cycle
//  op           in   3        ALU opcode; op[2:1]==2'b11 arithmetic, op[0]=0 add, 1 sub
//  result       in   WIDTH    ALU result
//  co_add       in   1        adder carry-out of MSB
//  co_prev_add  in   1        adder carry into MSB
//  co_sub       in   1        subtractor carry-out of MSB
//  co_prev_sub  in   1        subtractor carry into MSB
//  clr_sticky   in   1        clear c_sticky, v_sticky, ovf_count
//  out_valid    out  1        c/n/z/v updated from an in_valid sample last cycle
//  c, n, z, v   out  1 each   registered flags
//  c_sticky     out  1        OR of all c since reset/clear
//  v_sticky     out  1        OR of all v since reset/clear
//  ovf_count    out  CNT_W    number of v events since reset/clear, saturating
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. On reset: every output = 0, counter = 0.
//  - Next-flag rule (combinational, per sample):
//      arith = (op[2:1]==2'b11); sub = op[0]
//      c_nxt = arith ? (sub ? co_sub : co_add) : 0
//      v_nxt = arith ? (sub ? co_sub^co_prev_sub : co_add^co_prev_add) : 0
//      n_nxt = result[WIDTH-1];  z_nxt = (result == 0)
//  - Latency 1: in_valid at edge k -> c/n/z/v = *_nxt and out_valid=1 after edge k.
//  - in_valid=0: c/n/z/v hold last value; out_valid=0. No back-pressure; a sample every cycle is legal.
//  - Sticky: on in_valid, c_sticky |= c_nxt, v_sticky |= v_nxt.
//  - Counter: on in_valid & v_nxt, ovf_count += 1 unless already all-ones (saturates, never wraps).
//  - clr_sticky alone: c_sticky=v_sticky=0, ovf_count=0 next cycle; c/n/z/v unaffected.
//  - clr_sticky with in_valid same cycle: clear first, then apply the new sample
//    (c_sticky=c_nxt, v_sticky=v_nxt, ovf_count = v_nxt ? 1 : 0).
//  - reset has priority over clr_sticky and in_valid; reset mid-stream discards the sample of that cycle.
//  - Non-arithmetic op never sets c/v or the sticky flags, but still updates n/z.
// STRUCTURE
//  - Shared package/header: OP_ARITH = 2'b11, OP_ADD = 1'b0, OP_SUB = 1'b1.
//  - Sub-module alu_flags_next (combinational, WIDTH param): produces c_nxt/n_nxt/z_nxt/v_nxt.
//  - Top: flag register, sticky register, saturating counter, out_valid flop.
// TESTING (WIDTH=32, CNT_W=2 unless stated)
//  1 reset=1 for 2 cycles with in_valid=1 random -> all outputs 0, out_valid=0 throughout and 1 cycle after.
//  2 op=110, result=0x0000_0000, co_add=1, co_prev_add=1 -> next cycle c=1,z=1,n=0,v=0,out_valid=1.
//  3 op=111, result=0x8000_0000, co_sub=0, co_prev_sub=1 -> c=0,n=1,v=1,v_sticky=1,ovf_count=1;
//    next 3 cycles in_valid=0 -> flags hold, out_valid=0.
//  4 four consecutive add overflows (co_add=0, co_prev_add=1) -> ovf_count 1,2,3,3 (saturated).
//  5 op=010 with co_add=1, co_prev_add=0, result=0x0000_0001 -> c=0,v=0,n=0,z=0; stickies unchanged.
//  6 v_sticky=1, ovf_count=3, then clr_sticky=1 with in_valid overflow sample -> v_sticky=1, ovf_count=1;
//    next cycle clr_sticky=1 alone -> v_sticky=0, c_sticky=0, ovf_count=0, c/n/z/v held.

Source files
------------

// File: rtl/cal_flags_reg_pkg.sv
// Shared opcode encodings and flag bundle type for the registered ALU status-flag unit.
package cal_flags_reg_pkg;

  localparam logic [1:0] OP_ARITH = 2'b11;
  localparam logic       OP_ADD   = 1'b0;
  localparam logic       OP_SUB   = 1'b1;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
    logic v;
  } flags_t;

endpackage

// File: rtl/cal_flags_reg_alu_flags_next.sv
// Combinational next-flag calculator: C/V only for add/sub opcodes, N/Z always from the result.
module alu_flags_next
  import cal_flags_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_co_add,
  input  logic             i_co_prev_add,
  input  logic             i_co_sub,
  input  logic             i_co_prev_sub,
  output flags_t           o_flags
);

  logic w_arith;
  logic w_sub;

  always_comb begin
    w_arith   = (i_op[2:1] == OP_ARITH);
    w_sub     = (i_op[0] == OP_SUB);
    o_flags   = '0;
    o_flags.n = i_result[WIDTH-1];
    o_flags.z = (i_result == '0);
    if (w_arith) begin
      // Signed overflow is the carry into the MSB disagreeing with the carry out of it.
      o_flags.c = w_sub ? i_co_sub : i_co_add;
      o_flags.v = w_sub ? (i_co_sub ^ i_co_prev_sub) : (i_co_add ^ i_co_prev_add);
    end
  end

endmodule

// File: rtl/cal_flags_reg.sv
// Registered C/N/Z/V flags with valid strobe, sticky carry/overflow and a saturating overflow counter.
module cal_flags_reg
  import cal_flags_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             co_add,
  input  logic             co_prev_add,
  input  logic             co_sub,
  input  logic             co_prev_sub,
  input  logic             clr_sticky,
  output logic             out_valid,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             c_sticky,
  output logic             v_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  flags_t           w_nxt;
  flags_t           r_flags;
  logic             r_out_valid;
  logic             r_c_sticky;
  logic             r_v_sticky;
  logic [CNT_W-1:0] r_ovf_count;

  logic             w_c_sticky_nxt;
  logic             w_v_sticky_nxt;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_nxt;

  alu_flags_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .i_op          (op),
    .i_result      (result),
    .i_co_add      (co_add),
    .i_co_prev_add (co_prev_add),
    .i_co_sub      (co_sub),
    .i_co_prev_sub (co_prev_sub),
    .o_flags       (w_nxt)
  );

  // A clear in the same cycle as a sample is applied first, so the sample lands on a zeroed base.
  always_comb begin
    w_c_sticky_nxt = clr_sticky ? 1'b0 : r_c_sticky;
    w_v_sticky_nxt = clr_sticky ? 1'b0 : r_v_sticky;
    w_cnt_base     = clr_sticky ? '0 : r_ovf_count;
    w_cnt_nxt      = w_cnt_base;
    if (in_valid) begin
      w_c_sticky_nxt = w_c_sticky_nxt | w_nxt.c;
      w_v_sticky_nxt = w_v_sticky_nxt | w_nxt.v;
      if (w_nxt.v && (w_cnt_base != '1)) begin
        w_cnt_nxt = w_cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_c_sticky  <= 1'b0;
      r_v_sticky  <= 1'b0;
      r_ovf_count <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_flags <= w_nxt;
      end
      r_c_sticky  <= w_c_sticky_nxt;
      r_v_sticky  <= w_v_sticky_nxt;
      r_ovf_count <= w_cnt_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign c         = r_flags.c;
  assign n         = r_flags.n;
  assign z         = r_flags.z;
  assign v         = r_flags.v;
  assign c_sticky  = r_c_sticky;
  assign v_sticky  = r_v_sticky;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_cal_flags_reg.sv
// Scoreboard bench for cal_flags_reg: directed scenarios followed by randomized traffic vs a reference model.
module tb_cal_flags_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] result;
  logic             co_add, co_prev_add, co_sub, co_prev_sub;
  logic             clr_sticky;
  logic             out_valid, c, n, z, v, c_sticky, v_sticky;
  logic [CNT_W-1:0] ovf_count;

  cal_flags_reg #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .op          (op),
    .result      (result),
    .co_add      (co_add),
    .co_prev_add (co_prev_add),
    .co_sub      (co_sub),
    .co_prev_sub (co_prev_sub),
    .clr_sticky  (clr_sticky),
    .out_valid   (out_valid),
    .c           (c),
    .n           (n),
    .z           (z),
    .v           (v),
    .c_sticky    (c_sticky),
    .v_sticky    (v_sticky),
    .ovf_count   (ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6+CNT_W:0] exp;
    string            tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state, expressed directly from the flag rules.
  bit m_ov, m_c, m_n, m_z, m_v, m_cs, m_vs;
  int m_cnt;

  function automatic logic [6+CNT_W:0] pack_model();
    logic [CNT_W-1:0] cnt;
    cnt = CNT_W'(m_cnt);
    return {m_ov, m_c, m_n, m_z, m_v, m_cs, m_vs, cnt};
  endfunction

  task automatic drive(input string tag, input bit rst, input bit iv, input logic [2:0] o,
                       input logic [WIDTH-1:0] res, input bit ca, input bit cpa,
                       input bit cs, input bit cps, input bit clr);
    exp_t e;
    bit   is_arith, is_sub, cn, vn;
    @(negedge clk);
    reset = rst; in_valid = iv; op = o; result = res;
    co_add = ca; co_prev_add = cpa; co_sub = cs; co_prev_sub = cps; clr_sticky = clr;
    if (rst) begin
      {m_ov, m_c, m_n, m_z, m_v, m_cs, m_vs} = '0;
      m_cnt = 0;
    end else begin
      m_ov = iv;
      if (clr) begin
        m_cs = 0; m_vs = 0; m_cnt = 0;
      end
      if (iv) begin
        is_arith = (o[2] && o[1]);
        is_sub   = o[0];
        cn = is_arith && (is_sub ? cs : ca);
        vn = is_arith && (is_sub ? (cs != cps) : (ca != cpa));
        m_c = cn; m_v = vn;
        m_n = res[WIDTH-1];
        m_z = (res == 0);
        m_cs = m_cs || cn;
        m_vs = m_vs || vn;
        if (vn) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
    end
    e.exp = pack_model();
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic idle(input string tag);
    drive(tag, 0, 0, 3'($urandom), $urandom, 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 0);
  endtask

  // Monitor: one expected snapshot per driven cycle, compared just after the edge.
  initial begin
    exp_t             e;
    logic [6+CNT_W:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {out_valid, c, n, z, v, c_sticky, v_sticky, ovf_count};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got {ov,c,n,z,v,cs,vs,cnt}=%b required %b", e.tag, act, e.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; in_valid = 0; op = '0; result = '0;
    co_add = 0; co_prev_add = 0; co_sub = 0; co_prev_sub = 0; clr_sticky = 0;

    drive("reset0", 1, 1, 3'b110, $urandom, 1, 0, 1, 0, 0);
    drive("reset1", 1, 1, 3'b111, $urandom, 1, 1, 0, 1, 1);
    idle("post_reset");

    drive("add_zero_carry", 0, 1, 3'b110, 32'h0000_0000, 1, 1, 0, 0, 0);

    drive("sub_neg_ovf", 0, 1, 3'b111, 32'h8000_0000, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) idle("hold");

    drive("clr_only_pre", 0, 0, 3'b000, 32'h1234_5678, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      drive("add_ovf_sat", 0, 1, 3'b110, $urandom, 0, 1, 0, 0, 0);

    drive("nonarith", 0, 1, 3'b010, 32'h0000_0001, 1, 0, 1, 0, 0);

    drive("clr_with_ovf", 0, 1, 3'b110, 32'h7fff_ffff, 0, 1, 0, 0, 1);
    drive("clr_alone", 0, 0, 3'b110, 32'h0, 1, 0, 1, 0, 1);
    idle("hold_after_clr");

    for (int i = 0; i < 2000; i++) begin
      logic [WIDTH-1:0] r;
      int               sel;
      sel = $urandom_range(0, 9);
      r = $urandom;
      if (sel == 0) r = '0;
      else if (sel == 1) r = 32'h8000_0000;
      drive("random",
            ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1) ? {2'b11, 1'($urandom)} : 3'($urandom),
            r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 15) == 0));
    end

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
